// File: rtl/mem_bist_ctrl.sv
// mem_bist_ctrl -- single-pass memory self-test sequencer.
//
// Writes an address-keyed pattern (address XOR SEED) to every word of the
// memory. It then reads every word back, compares each word with the pattern
// and reports the result.
//
// Ports:
//   clk             - single clock, rising edge
//   rst             - asynchronous, active-high reset
//   start           - test request, sampled only while idle
//   mem_write       - memory write strobe
//   mem_read        - memory read strobe
//   mem_addr        - memory word address (MSB always 0)
//   mem_wdata       - memory write data
//   mem_rdata       - memory read data, valid one cycle after the read strobe
//   busy            - high whenever a test is in progress
//   done            - one-cycle pulse at test completion
//   pass            - last completed test saw no mismatches
//   err_count       - mismatch count of the current or last test
//   first_fail_addr - address of the first mismatch (valid when err_count != 0)
module mem_bist_ctrl #(
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  mem_write,
    output logic                  mem_read,
    output logic [ADDR_WIDTH:0]   mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH:0]   err_count,
    output logic [ADDR_WIDTH-1:0] first_fail_addr
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WRITE      = 3'd1,
        READ       = 3'd2,
        CHECK_LAST = 3'd3,
        DONE       = 3'd4
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = {ADDR_WIDTH{1'b1}};
    localparam logic [ADDR_WIDTH:0]   ERR_ZERO  = (ADDR_WIDTH + 1)'(0);
    localparam logic [ADDR_WIDTH:0]   ERR_ONE   = (ADDR_WIDTH + 1)'(1);

    // Test pattern for one word. The sized cast truncates a wide address or
    // zero-extends a narrow one to the data width.
    function automatic logic [DATA_WIDTH-1:0] pattern_of(input logic [ADDR_WIDTH-1:0] addr);
        return DATA_WIDTH'(addr) ^ SEED;
    endfunction

    state_t                  state_r;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic [ADDR_WIDTH-1:0]   exp_addr_r;
    logic                    valid_r;
    logic [ADDR_WIDTH-1:0]   cnt_inc_s;
    logic                    mismatch_s;

    // Next address and read-data compare against the expected pattern.
    always_comb begin
        cnt_inc_s  = cnt_r + ADDR_ONE;
        mismatch_s = 1'b0;
        if (valid_r) begin
            mismatch_s = (mem_rdata != pattern_of(exp_addr_r));
        end else begin
            mismatch_s = 1'b0;
        end
    end

    // Sequencer FSM with registered memory strobes and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r         <= IDLE;
            cnt_r           <= ADDR_ZERO;
            exp_addr_r      <= ADDR_ZERO;
            valid_r         <= 1'b0;
            mem_write       <= 1'b0;
            mem_read        <= 1'b0;
            mem_addr        <= ERR_ZERO;
            mem_wdata       <= DATA_WIDTH'(0);
            busy            <= 1'b0;
            done            <= 1'b0;
            pass            <= 1'b0;
            err_count       <= ERR_ZERO;
            first_fail_addr <= ADDR_ZERO;
        end else begin
            // The address on the bus this cycle is the one whose data the
            // memory returns next cycle, so capture it as the expected tag.
            exp_addr_r <= mem_addr[ADDR_WIDTH-1:0];
            valid_r    <= mem_read;
            done       <= 1'b0;

            if (mismatch_s) begin
                err_count <= err_count + ERR_ONE;
                if (err_count == ERR_ZERO) begin
                    first_fail_addr <= exp_addr_r;
                end
            end

            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= WRITE;
                        cnt_r     <= ADDR_ZERO;
                        err_count <= ERR_ZERO;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                        mem_write <= 1'b1;
                        mem_read  <= 1'b0;
                        mem_addr  <= {1'b0, ADDR_ZERO};
                        mem_wdata <= pattern_of(ADDR_ZERO);
                    end
                end
                WRITE: begin
                    if (cnt_r == ADDR_LAST) begin
                        state_r   <= READ;
                        cnt_r     <= ADDR_ZERO;
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= {1'b0, ADDR_ZERO};
                        mem_wdata <= DATA_WIDTH'(0);
                    end else begin
                        cnt_r     <= cnt_inc_s;
                        mem_addr  <= {1'b0, cnt_inc_s};
                        mem_wdata <= pattern_of(cnt_inc_s);
                    end
                end
                READ: begin
                    if (cnt_r == ADDR_LAST) begin
                        state_r  <= CHECK_LAST;
                        cnt_r    <= ADDR_ZERO;
                        mem_read <= 1'b0;
                        mem_addr <= {1'b0, ADDR_ZERO};
                    end else begin
                        cnt_r    <= cnt_inc_s;
                        mem_addr <= {1'b0, cnt_inc_s};
                    end
                end
                CHECK_LAST: begin
                    // Wait until the final read has been compared and counted,
                    // so that pass reflects every word.
                    if (!valid_r) begin
                        state_r <= DONE;
                        done    <= 1'b1;
                        pass    <= (err_count == ERR_ZERO);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    state_r   <= IDLE;
                    busy      <= 1'b0;
                    mem_write <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_addr  <= ERR_ZERO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Testbench for mem_bist_ctrl: behavioural memory with injectable faults,
// expected results computed per address from the pattern rule.
module tb_mem_bist_ctrl;

    localparam int          AW    = 5;
    localparam int          DW    = 8;
    localparam int          NADDR = 32;
    localparam int          LAT   = 66;
    localparam int          NOBS  = 150;
    localparam logic [7:0]  SEED_TB = 8'hA5;

    logic          clk;
    logic          rst;
    logic          start;
    logic          mem_write;
    logic          mem_read;
    logic [AW:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          done;
    logic          pass;
    logic [AW:0]   err_count;
    logic [AW-1:0] first_fail_addr;

    int tests_run;
    int tests_failed;

    logic [7:0] mem   [NADDR];
    logic [7:0] or_m  [NADDR];
    logic [7:0] xor_m [NADDR];

    logic        obs_wr    [NOBS];
    logic        obs_rd    [NOBS];
    logic        obs_busy  [NOBS];
    logic        obs_pass  [NOBS];
    logic [AW:0] obs_addr  [NOBS];
    logic [7:0]  obs_wdata [NOBS];
    int          done_q[$];

    int   m_err;
    int   m_first;
    logic m_pass;

    mem_bist_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SEED       (SEED_TB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .mem_write       (mem_write),
        .mem_read        (mem_read),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rdata       (mem_rdata),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_addr (first_fail_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory with per-word stuck-at-1 (or) and flip (xor) read faults.
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[AW-1:0]] <= mem_wdata;
        if (mem_read)  mem_rdata <= (mem[mem_addr[AW-1:0]] | or_m[mem_addr[AW-1:0]]) ^ xor_m[mem_addr[AW-1:0]];
    end

    // Strobe exclusivity and address MSB, every cycle outside reset.
    always @(negedge clk) begin
        if (!rst) begin
            tests_run++;
            if ((mem_read === 1'b1 && mem_write === 1'b1) || mem_addr[AW] !== 1'b0) begin
                tests_failed++;
                $display("FAIL protocol: rd=%b wr=%b addr=%h required not both and msb 0", mem_read, mem_write, mem_addr);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_faults();
        for (int a = 0; a < NADDR; a++) begin
            or_m[a]  = 8'h00;
            xor_m[a] = 8'h00;
        end
    endtask

    // Expected outcome: a word fails when what the memory returns differs
    // from address XOR seed.
    task automatic model_expect();
        logic [7:0] pat;
        logic [7:0] rd;
        m_err   = 0;
        m_first = -1;
        for (int a = 0; a < NADDR; a++) begin
            pat = 8'(a) ^ SEED_TB;
            rd  = (pat | or_m[a]) ^ xor_m[a];
            if (rd != pat) begin
                m_err++;
                if (m_first < 0) m_first = a;
            end
        end
        m_pass = (m_err == 0);
    endtask

    // Pulse (or hold) start and record outputs each cycle after the start edge.
    task automatic run_once(input int glitch_cyc, input bit hold, input int ncyc);
        done_q.delete();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            obs_wr[c]    = mem_write;
            obs_rd[c]    = mem_read;
            obs_busy[c]  = busy;
            obs_pass[c]  = pass;
            obs_addr[c]  = mem_addr;
            obs_wdata[c] = mem_wdata;
            if (done === 1'b1) done_q.push_back(c);
            if (c == glitch_cyc) start = 1'b1;
            else if (!hold || c >= 68) start = 1'b0;
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        tests_run++; if (mem_write !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_write: got %b need 0", mem_write); end
        tests_run++; if (mem_read !== 1'b0) begin tests_failed++; $display("FAIL reset_mem_read: got %b need 0", mem_read); end
        tests_run++; if (mem_addr !== 6'd0) begin tests_failed++; $display("FAIL reset_mem_addr: got %h need 0", mem_addr); end
        tests_run++; if (mem_wdata !== 8'd0) begin tests_failed++; $display("FAIL reset_mem_wdata: got %h need 0", mem_wdata); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b need 0", busy); end
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b need 0", done); end
        tests_run++; if (pass !== 1'b0) begin tests_failed++; $display("FAIL reset_pass: got %b need 0", pass); end
        tests_run++; if (err_count !== 6'd0) begin tests_failed++; $display("FAIL reset_err_count: got %0d need 0", err_count); end
        tests_run++; if (first_fail_addr !== 5'd0) begin tests_failed++; $display("FAIL reset_first_fail: got %0d need 0", first_fail_addr); end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || mem_write !== 1'b0 || mem_read !== 1'b0) begin
            tests_failed++;
            $display("FAIL no_autostart: busy=%b wr=%b rd=%b need all 0", busy, mem_write, mem_read);
        end
    endtask

    task automatic test_fault_free();
        logic        e_wr, e_rd, e_busy;
        logic [AW:0] e_addr;
        logic [7:0]  e_wdata;
        clear_faults();
        model_expect();
        run_once(-1, 1'b0, 72);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != LAT) begin
            tests_failed++;
            $display("FAIL ff_done_cycle: got %0d pulses first at %0d need 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, LAT);
        end
        for (int c = 0; c < 68; c++) begin
            e_wr    = (c < NADDR);
            e_rd    = (c >= NADDR && c < 2 * NADDR);
            e_busy  = (c <= LAT);
            e_addr  = (c < NADDR) ? 6'(c) : ((c < 2 * NADDR) ? 6'(c - NADDR) : 6'd0);
            e_wdata = 8'(c) ^ SEED_TB;
            tests_run++;
            if (obs_wr[c] !== e_wr || obs_rd[c] !== e_rd || obs_busy[c] !== e_busy ||
                ((e_wr || e_rd) && obs_addr[c] !== e_addr) || (e_wr && obs_wdata[c] !== e_wdata)) begin
                tests_failed++;
                $display("FAIL ff_schedule cyc %0d: got wr=%b rd=%b busy=%b addr=%h wdata=%h need wr=%b rd=%b busy=%b addr=%h wdata=%h",
                         c, obs_wr[c], obs_rd[c], obs_busy[c], obs_addr[c], obs_wdata[c], e_wr, e_rd, e_busy, e_addr, e_wdata);
            end
        end
        tests_run++;
        if (obs_wdata[3] !== 8'hA6) begin tests_failed++; $display("FAIL ff_wdata_addr3: got %h need a6", obs_wdata[3]); end
        tests_run++;
        if (err_count !== 6'(m_err) || pass !== m_pass) begin
            tests_failed++;
            $display("FAIL ff_result: got err=%0d pass=%b need err=%0d pass=%b", err_count, pass, m_err, m_pass);
        end
        repeat (5) @(negedge clk);
        tests_run++;
        if (err_count !== 6'(m_err) || pass !== m_pass || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL ff_hold_idle: got err=%0d pass=%b busy=%b need err=%0d pass=%b busy=0", err_count, pass, busy, m_err, m_pass);
        end
    endtask

    // Common result check for fault runs.
    task automatic check_fault_run(input string name);
        model_expect();
        run_once(-1, 1'b0, 72);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != LAT) begin
            tests_failed++;
            $display("FAIL %s_done: got %0d pulses first at %0d need 1 at %0d", name, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, LAT);
        end
        tests_run++;
        if (err_count !== 6'(m_err) || pass !== m_pass) begin
            tests_failed++;
            $display("FAIL %s_result: got err=%0d pass=%b need err=%0d pass=%b", name, err_count, pass, m_err, m_pass);
        end
        if (m_err != 0) begin
            tests_run++;
            if (first_fail_addr !== 5'(m_first)) begin
                tests_failed++;
                $display("FAIL %s_first_fail: got %0d need %0d", name, first_fail_addr, m_first);
            end
        end
    endtask

    task automatic test_single_stuck();
        clear_faults();
        or_m[4] = 8'h02;
        check_fault_run("stuck4");
        tests_run++;
        if (obs_pass[5] !== 1'b0) begin tests_failed++; $display("FAIL stuck4_pass_cleared: got %b need 0", obs_pass[5]); end
    endtask

    task automatic test_multi_fault();
        clear_faults();
        xor_m[31] = 8'h10;
        xor_m[7]  = 8'h81;
        check_fault_run("multi");
    endtask

    task automatic test_random();
        int nf;
        int a;
        for (int it = 0; it < 6; it++) begin
            clear_faults();
            nf = $urandom_range(0, 5);
            for (int k = 0; k < nf; k++) begin
                a = $urandom_range(0, NADDR - 1);
                if ($urandom_range(0, 1) == 1) or_m[a] = 8'($urandom_range(1, 255));
                else xor_m[a] = 8'($urandom_range(1, 255));
            end
            check_fault_run($sformatf("rand%0d", it));
        end
    endtask

    task automatic test_start_while_busy();
        clear_faults();
        run_once(10, 1'b0, 72);
        tests_run++;
        if (done_q.size() != 1 || done_q[0] != LAT) begin
            tests_failed++;
            $display("FAIL busy_start_done: got %0d pulses first at %0d need 1 at %0d", done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, LAT);
        end
        tests_run++;
        if (obs_busy[67] !== 1'b0 || obs_busy[71] !== 1'b0 || pass !== 1'b1) begin
            tests_failed++;
            $display("FAIL busy_start_no_queue: got busy67=%b busy71=%b pass=%b need 0 0 1", obs_busy[67], obs_busy[71], pass);
        end
    endtask

    task automatic test_mid_reset();
        clear_faults();
        xor_m[0] = 8'h01;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if (mem_write !== 1'b0 || mem_read !== 1'b0 || mem_addr !== 6'd0 || mem_wdata !== 8'd0 || busy !== 1'b0 ||
            done !== 1'b0 || pass !== 1'b0 || err_count !== 6'd0 || first_fail_addr !== 5'd0) begin
            tests_failed++;
            $display("FAIL midrst_outputs: got wr=%b rd=%b addr=%h wd=%h busy=%b done=%b pass=%b err=%0d ffa=%0d need all 0",
                     mem_write, mem_read, mem_addr, mem_wdata, busy, done, pass, err_count, first_fail_addr);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_idle: got busy=%b rd=%b wr=%b need 0 0 0", busy, mem_read, mem_write);
        end
        clear_faults();
        check_fault_run("midrst_rerun");
    endtask

    task automatic test_back_to_back();
        clear_faults();
        xor_m[12] = 8'h40;
        model_expect();
        run_once(-1, 1'b1, 140);
        tests_run++;
        if (done_q.size() != 2 || done_q[0] != LAT || done_q[1] != 2 * LAT + 2) begin
            tests_failed++;
            $display("FAIL b2b_done: got %0d pulses at %0d,%0d need 2 at %0d,%0d", done_q.size(),
                     (done_q.size() > 0) ? done_q[0] : -1, (done_q.size() > 1) ? done_q[1] : -1, LAT, 2 * LAT + 2);
        end
        tests_run++;
        if (obs_busy[67] !== 1'b0 || obs_wr[68] !== 1'b1 || obs_addr[68] !== 6'd0 || obs_busy[68] !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_restart: got busy67=%b wr68=%b addr68=%h busy68=%b need 0 1 0 1", obs_busy[67], obs_wr[68], obs_addr[68], obs_busy[68]);
        end
        tests_run++;
        if (err_count !== 6'(m_err) || pass !== m_pass || first_fail_addr !== 5'(m_first) || obs_busy[139] !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_result: got err=%0d pass=%b ffa=%0d busy=%b need err=%0d pass=%b ffa=%0d busy=0",
                     err_count, pass, first_fail_addr, obs_busy[139], m_err, m_pass, m_first);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        clear_faults();
        test_reset();
        test_fault_free();
        test_single_stuck();
        test_multi_fault();
        test_random();
        test_start_while_busy();
        test_mid_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
